// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed multiply/divide engine with HI/LO result registers.
//   MULT: radix-2 Booth, one step per cycle (32 run cycles + DONE).
//   DIV : restoring division on magnitudes (32 run cycles + sign fix + DONE).
// Ports:
//   clk, reset_in    clock and synchronous active-high reset
//   start, op, a, b  request pulse, op select (0 = MULT, 1 = DIV) and operands
//   busy, done, div0 registered status outputs
//   hi, lo           architectural HI/LO registers
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StMulRun = 3'd1;
  localparam logic [2:0] StDivRun = 3'd2;
  localparam logic [2:0] StDivFix = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;
  localparam logic [2:0] StExc    = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Upper accumulator is one bit wider so Booth add/sub of -2^(W-1) never overflows.
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  // Multiplicand (sign-extended) for MULT, divisor magnitude for DIV.
  logic [WIDTH:0]   mcand_q, mcand_d;
  logic             qm1_q, qm1_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic             last_step;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_hi_nxt;
  logic [WIDTH-1:0] booth_lo_nxt;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] quo_signed, rem_signed;

  assign last_step = (cnt_q == CntW'(WIDTH - 1));

  // Booth step: {q0, q-1} = 01 adds, 10 subtracts, then arithmetic shift of {A, Q, q-1}.
  always_comb begin
    booth_sum = acc_hi_q;
    case ({acc_lo_q[0], qm1_q})
      2'b01:   booth_sum = acc_hi_q + mcand_q;
      2'b10:   booth_sum = acc_hi_q - mcand_q;
      default: booth_sum = acc_hi_q;
    endcase
  end

  assign booth_hi_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_lo_nxt = {booth_sum[0], acc_lo_q[WIDTH-1:1]};

  // Restoring step: remainder always stays below the divisor, so WIDTH bits of it suffice.
  assign rem_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
  assign trial     = {1'b0, rem_shift} - {1'b0, mcand_q};
  assign trial_ok  = ~trial[WIDTH+1];

  // Unsigned magnitudes; 2^(W-1) is representable as an unsigned WIDTH-bit value.
  assign a_mag = a[WIDTH-1] ? (-a) : a;
  assign b_mag = b[WIDTH-1] ? (-b) : b;

  assign quo_signed = (sign_a_q ^ sign_b_q) ? (-acc_lo_q) : acc_lo_q;
  assign rem_signed = sign_a_q ? (-acc_hi_q[WIDTH-1:0]) : acc_hi_q[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    qm1_d    = qm1_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      // DONE behaves like IDLE for a new request so back-to-back starts are accepted.
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          cnt_d = '0;
          if (!op) begin
            state_d  = StMulRun;
            acc_hi_d = '0;
            acc_lo_d = b;
            mcand_d  = {a[WIDTH-1], a};
            qm1_d    = 1'b0;
          end else if (b == '0) begin
            state_d = StExc;
          end else begin
            state_d  = StDivRun;
            acc_hi_d = '0;
            acc_lo_d = a_mag;
            mcand_d  = {1'b0, b_mag};
            sign_a_d = a[WIDTH-1];
            sign_b_d = b[WIDTH-1];
          end
        end
      end
      StMulRun: begin
        acc_hi_d = booth_hi_nxt;
        acc_lo_d = booth_lo_nxt;
        qm1_d    = acc_lo_q[0];
        cnt_d    = cnt_q + CntW'(1);
        if (last_step) begin
          state_d = StDone;
          hi_d    = booth_hi_nxt[WIDTH-1:0];
          lo_d    = booth_lo_nxt;
        end
      end
      StDivRun: begin
        if (trial_ok) begin
          acc_hi_d = trial[WIDTH:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = rem_shift;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CntW'(1);
        if (last_step) begin
          state_d = StDivFix;
        end
      end
      StDivFix: begin
        state_d = StDone;
        hi_d    = rem_signed;
        lo_d    = quo_signed;
      end
      StExc:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == StMulRun) || (state_d == StDivRun) ||
             (state_d == StDivFix) || (state_d == StDone);
    done_d = (state_d == StDone);
    div0_d = (state_d == StExc);
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      qm1_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      qm1_q    <= qm1_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and random MULT/DIV with a
// result scoreboard, plus reset, divide-by-zero, ignored-start and back-to-back cases.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div0     (div0),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit signed arithmetic, so INT_MIN / -1 wraps to INT_MIN in the low word.
  function automatic logic [63:0] model(input logic o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, p, q, r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (!o) begin
      p = sx * sy;
      return p;
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a start for one cycle; returns in cycle E+1.
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] m;
    m     = model(o, x, y);
    e.hi  = m[63:32];
    e.lo  = m[31:0];
    e.lat = o ? 34 : 33;
    sb.push_back(e);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for done starting at cycle E+n0; stays in the done cycle on return.
  task automatic wait_done(input string tag, input int n0);
    exp_t e;
    int   n;
    n = n0;
    for (int k = 0; k < 80; k++) begin
      if (done === 1'b1) break;
      step();
      n++;
    end
    if (sb.size() != 0) e = sb.pop_front();
    else begin
      e.hi  = 32'hxxxxxxxx;
      e.lo  = 32'hxxxxxxxx;
      e.lat = -1;
    end
    check({tag, "_lat"}, 64'(n), 64'(e.lat));
    check({tag, "_hi"}, {32'h0, hi}, {32'h0, e.hi});
    check({tag, "_lo"}, {32'h0, lo}, {32'h0, e.lo});
    check({tag, "_busy_in_done"}, {63'h0, busy}, 64'h1);
  endtask

  task automatic after_done(input string tag);
    step();
    check({tag, "_busy_after"}, {63'h0, busy}, 64'h0);
    check({tag, "_done_after"}, {63'h0, done}, 64'h0);
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] x,
                        input logic [31:0] y);
    issue(o, x, y);
    wait_done(tag, 1);
    after_done(tag);
  endtask

  initial begin
    logic        seen_done, seen_busy, seen_div0;
    logic [31:0] rx, ry;

    reset_in = 1'b1;
    start    = 1'b0;
    op       = 1'b0;
    a        = '0;
    b        = '0;
    step();
    step();
    reset_in = 1'b0;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_div0", {63'h0, div0}, 64'h0);
    check("rst_hilo", {hi, lo}, 64'h0);

    // Signed multiply, with busy checked in E+1
    issue(1'b0, 32'hFFFFFFFD, 32'h00000005);
    check("mul1_busy_e1", {63'h0, busy}, 64'h1);
    wait_done("mul1", 1);
    check("mul1_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    after_done("mul1");
    run_op("mul_minmin", 1'b0, 32'h80000000, 32'h80000000);
    check("mul_minmin_const", {hi, lo}, 64'h40000000_00000000);

    // Signed divide
    run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002);
    check("div_m7_2_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE);
    check("div_7_m2_const", {hi, lo}, 64'h00000001_FFFFFFFD);
    run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
    check("div_min_m1_const", {hi, lo}, 64'h00000000_80000000);

    // Random operands
    for (int i = 0; i < 4; i++) begin
      rx = $urandom;
      ry = $urandom;
      run_op("mul_rand", 1'b0, rx, ry);
      rx = $urandom;
      ry = $urandom >> $urandom_range(0, 28);
      if (ry == 32'h0) ry = 32'h3;
      if (i[0]) ry = -ry;
      run_op("div_rand", 1'b1, rx, ry);
    end

    // Divide by zero: preload HI=0x11, LO=0x22 via 0x451 / 0x20
    run_op("div_prep", 1'b1, 32'h00000451, 32'h00000020);
    op    = 1'b1;
    a     = 32'h5;
    b     = 32'h0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("div0_e1", {63'h0, div0}, 64'h1);
    check("div0_busy_e1", {63'h0, busy}, 64'h0);
    check("div0_done_e1", {63'h0, done}, 64'h0);
    step();
    check("div0_e2", {63'h0, div0}, 64'h0);
    seen_busy = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen_busy |= busy;
      seen_done |= done;
      step();
    end
    check("div0_no_busy", {63'h0, seen_busy}, 64'h0);
    check("div0_no_done", {63'h0, seen_done}, 64'h0);
    check("div0_hilo_kept", {hi, lo}, 64'h00000011_00000022);

    // Reset mid-operation: MULT 7x6, reset sampled at edge E+10
    op    = 1'b0;
    a     = 32'd7;
    b     = 32'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_done", {63'h0, done}, 64'h0);
    check("midrst_hilo", {hi, lo}, 64'h0);
    seen_done = 1'b0;
    for (int k = 0; k < 45; k++) begin
      seen_done |= done;
      step();
    end
    check("midrst_no_done", {63'h0, seen_done}, 64'h0);

    // Ignored start: DIV-by-zero request sampled at E+5 of MULT 3x4
    issue(1'b0, 32'd3, 32'd4);
    repeat (3) step();
    op    = 1'b1;
    a     = 32'd100;
    b     = 32'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ign", 5);
    check("ign_const", {hi, lo}, 64'h00000000_0000000C);
    seen_done = 1'b0;
    seen_div0 = 1'b0;
    for (int k = 0; k < 45; k++) begin
      step();
      seen_done |= done;
      seen_div0 |= div0;
    end
    check("ign_single_done", {63'h0, seen_done}, 64'h0);
    check("ign_no_div0", {63'h0, seen_div0}, 64'h0);

    // Back-to-back: MULT start sampled at the edge ending the DIV's DONE cycle
    issue(1'b1, 32'hFFFFFF9C, 32'h00000007);
    wait_done("b2b_div", 1);
    check("b2b_div_const", {hi, lo}, 64'hFFFFFFFE_FFFFFFF2);
    issue(1'b0, 32'h00012345, 32'hFFFF0000);
    check("b2b_busy_e1", {63'h0, busy}, 64'h1);
    wait_done("b2b_mul", 1);
    after_done("b2b_mul");

    // Start coincident with reset is dropped
    reset_in = 1'b1;
    op       = 1'b0;
    a        = 32'd5;
    b        = 32'd5;
    start    = 1'b1;
    step();
    reset_in = 1'b0;
    start    = 1'b0;
    seen_busy = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen_busy |= busy;
      seen_done |= done;
      step();
    end
    check("rststart_no_busy", {63'h0, seen_busy}, 64'h0);
    check("rststart_no_done", {63'h0, seen_done}, 64'h0);
    check("rststart_hilo", {hi, lo}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
